// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder: memory-side responder for the 65CE02 core bus.
// Paces each bus cycle with a combinational ready, fronts a single-outstanding
// req/ack memory port, and keeps one posted write that can forward to reads.
// A watchdog terminates any memory access that is never acknowledged.
module cpu_bus_responder #(
    parameter int WR_POST = 1,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_address,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_o,
    output logic        ready,
    output logic [7:0]  data_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        bus_error
);

    localparam logic [1:0] START   = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_RESP = 2'd2;
    localparam logic [1:0] WR_WAIT = 2'd3;

    localparam logic        POSTED   = (WR_POST != 0);
    localparam logic        WD_ON    = (TIMEOUT != 0);
    localparam logic [16:0] WD_LIMIT = 17'(TIMEOUT);

    logic [1:0]  state;
    logic [7:0]  rd_data_q;
    logic [15:0] wd_cnt;

    logic        buf_valid;
    logic [15:0] buf_addr;
    logic [7:0]  buf_data;

    // Decode of the current bus cycle; none of these depend on mem_ack or
    // mem_rdata, so ready and data_i have no path from the memory port.
    logic in_start;
    logic buf_hit;
    logic post_accept;
    logic fwd_read;
    logic rd_issue;
    logic wr_issue;
    logic drain_issue;

    assign in_start    = (state == START);
    assign buf_hit     = buf_valid && (cpu_address == buf_addr);
    assign post_accept = in_start && cpu_write && POSTED && !buf_valid;
    assign fwd_read    = in_start && !cpu_write && buf_hit;
    // A read miss waits for an empty buffer so writes reach memory in order.
    assign rd_issue    = in_start && !cpu_write && !buf_valid && !mem_req;
    assign wr_issue    = in_start && cpu_write && !POSTED && !mem_req;
    // The buffer only holds data while no read owns the port, so whenever the
    // port is idle and the buffer is full the drain may go out.
    assign drain_issue = buf_valid && !mem_req;

    // Memory-side completion: a real ack, or the watchdog giving up.
    logic ack_v;
    logic wd_fire;
    logic mem_done;

    assign ack_v    = mem_req && mem_ack;
    assign wd_fire  = WD_ON && mem_req && !mem_ack && (({1'b0, wd_cnt} + 17'd1) == WD_LIMIT);
    assign mem_done = ack_v || wd_fire;

    assign ready  = post_accept || fwd_read || (state == RD_RESP);
    assign data_i = fwd_read ? buf_data : rd_data_q;

    // Bus-cycle FSM and the registered read-return data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= START;
            rd_data_q <= 8'h00;
        end else begin
            // NOTE: state elements use non-blocking assignment so every
            // always_ff sees the pre-edge values, independent of block order.
            case (state)
                START: begin
                    if (rd_issue) begin
                        state <= RD_WAIT;
                    end else if (wr_issue) begin
                        state <= WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (ack_v) begin
                        rd_data_q <= mem_rdata;
                        state     <= RD_RESP;
                    end else if (wd_fire) begin
                        rd_data_q <= 8'hFF;
                        state     <= RD_RESP;
                    end
                end
                WR_WAIT: begin
                    if (mem_done) begin
                        state <= RD_RESP;
                    end
                end
                default: begin
                    state <= START;
                end
            endcase
        end
    end

    // Memory port: one request at a time, at least one idle cycle between.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0000;
            mem_wdata <= 8'h00;
        end else if (mem_req) begin
            if (mem_done) begin
                mem_req <= 1'b0;
            end
        end else if (rd_issue) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cpu_address;
        end else if (wr_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_address;
            mem_wdata <= cpu_data_o;
        end else if (drain_issue) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= buf_addr;
            mem_wdata <= buf_data;
        end
    end

    // Posted-write buffer: filled by a zero-wait write, emptied by its drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_valid <= 1'b0;
            buf_addr  <= 16'h0000;
            buf_data  <= 8'h00;
        end else if (post_accept) begin
            buf_valid <= 1'b1;
            buf_addr  <= cpu_address;
            buf_data  <= cpu_data_o;
        end else if (buf_valid && mem_done) begin
            // With the buffer full the only possible request is its drain;
            // a watchdog expiry drops the write rather than retrying it.
            buf_valid <= 1'b0;
        end
    end

    // Watchdog: counts request cycles, held at zero while the port is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt    <= 16'h0000;
            bus_error <= 1'b0;
        end else begin
            wd_cnt    <= mem_req ? (wd_cnt + 16'd1) : 16'h0000;
            bus_error <= wd_fire;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Testbench for cpu_bus_responder: a posted-write instance and an unposted
// instance share the core-side stimulus; each has its own memory responder.
module tb_cpu_bus_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        np_reset_n;
    logic [15:0] cpu_address;
    logic        cpu_write;
    logic [7:0]  cpu_data_o;

    logic        ready;
    logic [7:0]  data_i;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack   = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic        bus_error;

    logic        np_ready;
    logic [7:0]  np_data_i;
    logic        np_mem_req;
    logic        np_mem_we;
    logic [15:0] np_mem_addr;
    logic [7:0]  np_mem_wdata;
    logic        np_mem_ack   = 1'b0;
    logic [7:0]  np_mem_rdata = 8'h00;
    logic        np_bus_error;

    cpu_bus_responder #(.WR_POST(1), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_address(cpu_address),
        .cpu_write  (cpu_write),
        .cpu_data_o (cpu_data_o),
        .ready      (ready),
        .data_i     (data_i),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .bus_error  (bus_error)
    );

    cpu_bus_responder #(.WR_POST(0), .TIMEOUT(8)) dut_np (
        .clk        (clk),
        .reset_n    (np_reset_n),
        .cpu_address(cpu_address),
        .cpu_write  (cpu_write),
        .cpu_data_o (cpu_data_o),
        .ready      (np_ready),
        .data_i     (np_data_i),
        .mem_req    (np_mem_req),
        .mem_we     (np_mem_we),
        .mem_addr   (np_mem_addr),
        .mem_wdata  (np_mem_wdata),
        .mem_ack    (np_mem_ack),
        .mem_rdata  (np_mem_rdata),
        .bus_error  (np_bus_error)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model for the posted instance ----------------
    int          ack_delay = 0;     // ack in cycle ack_delay+1 of a request
    bit          hang      = 1'b0;  // never acknowledge
    int          req_cyc   = 0;
    logic [7:0]  store [logic [15:0]];
    logic [24:0] req_log [$];       // {we, addr, wdata (0 for reads)}
    int          disc_err   = 0;
    int          err_pulses = 0;
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic [24:0] prev_cmd   = '0;

    function automatic logic [7:0] mem_read(input logic [15:0] a);
        if (store.exists(a)) return store[a];
        if (a == 16'h1234) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always @(negedge clk) begin
        if (prev_req && prev_ack && mem_req) disc_err++;
        if (prev_req && !prev_ack && mem_req && ({mem_we, mem_addr, mem_wdata} != prev_cmd)) disc_err++;
        if (bus_error) err_pulses++;
        if (mem_req) begin
            if (req_cyc == 0) req_log.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
            if (!hang && req_cyc == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_read(mem_addr);
                if (mem_we) store[mem_addr] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
            end
            req_cyc++;
        end else begin
            mem_ack = 1'b0;
            req_cyc = 0;
        end
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_cmd = {mem_we, mem_addr, mem_wdata};
    end

    // ---------------- memory model for the unposted instance ----------------
    int          np_delay      = 0;
    bit          np_hang       = 1'b0;
    int          np_cyc        = 0;
    int          np_err_pulses = 0;
    logic [24:0] np_log [$];

    always @(negedge clk) begin
        if (np_bus_error) np_err_pulses++;
        if (np_mem_req) begin
            if (np_cyc == 0) np_log.push_back({np_mem_we, np_mem_addr, np_mem_wdata});
            np_mem_ack = (!np_hang && np_cyc == np_delay);
            np_cyc++;
        end else begin
            np_mem_ack = 1'b0;
            np_cyc     = 0;
        end
    end

    // ---------------- scoreboard and bus driver ----------------
    typedef struct {
        string      name;
        bit         is_read;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t        sb [$];
    logic [24:0] exp_log [$];

    task automatic bus_cycle(input bit use_np, input logic wr, input logic [15:0] addr,
                             input logic [7:0] wd, output int lat, output logic [7:0] rd);
        logic r;
        cpu_write   = wr;
        cpu_address = addr;
        cpu_data_o  = wd;
        lat = 0;
        r   = 1'b0;
        while (!r && lat < 200) begin
            @(negedge clk);
            lat++;
            r = use_np ? np_ready : ready;
        end
        rd = use_np ? np_data_i : data_i;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit use_np, input string name, input logic wr, input logic [15:0] addr,
                       input logic [7:0] wd, input logic [7:0] exp_data, input int exp_lat);
        exp_t       e;
        int         lat;
        logic [7:0] rd;
        e.name    = name;
        e.is_read = !wr;
        e.data    = exp_data;
        e.lat     = exp_lat;
        sb.push_back(e);
        bus_cycle(use_np, wr, addr, wd, lat, rd);
        e = sb.pop_front();
        check({e.name, "_latency"}, lat, e.lat);
        if (e.is_read) check({e.name, "_data"}, rd, e.data);
    endtask

    task automatic exp_req(input logic we, input logic [15:0] addr, input logic [7:0] wd);
        exp_log.push_back({we, addr, wd});
    endtask

    task automatic check_log(input string name, input int base);
        check({name, "_req_count"}, req_log.size() - base, exp_log.size());
        for (int i = 0; i < exp_log.size() && base + i < req_log.size(); i++)
            check($sformatf("%s_req%0d", name, i), req_log[base + i], exp_log[i]);
        exp_log.delete();
    endtask

    task automatic restart();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vt [10];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int eb;
        int n;

        // Stream with ack in the second request cycle: miss 3+1, hit/post 1,
        // stalled write 3+1, read behind a drain 5+2 (one less after a hit).
        vt[0] = '{1'b0, 16'h1235, 8'h00, 8'h7D, 4};
        vt[1] = '{1'b1, 16'h0010, 8'hAB, 8'h00, 1};
        vt[2] = '{1'b0, 16'h0010, 8'h00, 8'hAB, 1};
        vt[3] = '{1'b0, 16'h0020, 8'h00, 8'h7A, 6};
        vt[4] = '{1'b1, 16'h0030, 8'h11, 8'h00, 1};
        vt[5] = '{1'b1, 16'h0040, 8'h22, 8'h00, 4};
        vt[6] = '{1'b0, 16'h0030, 8'h00, 8'h11, 7};
        vt[7] = '{1'b0, 16'h0040, 8'h00, 8'h22, 4};
        vt[8] = '{1'b1, 16'h0050, 8'h33, 8'h00, 1};
        vt[9] = '{1'b0, 16'h0051, 8'h00, 8'h0B, 7};

        reset_n     = 1'b0;
        np_reset_n  = 1'b0;
        cpu_write   = 1'b0;
        cpu_address = 16'h0000;
        cpu_data_o  = 8'h00;
        #12;
        check("rst_ready",     ready,     1'b0);
        check("rst_data_i",    data_i,    8'h00);
        check("rst_mem_req",   mem_req,   1'b0);
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  16'h0000);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_bus_error", bus_error, 1'b0);

        // Plain memory read, ack in the first request cycle.
        restart();
        ack_delay = 0;
        base = req_log.size();
        exp_req(1'b0, 16'h1234, 8'h00);
        run(0, "s1_read", 1'b0, 16'h1234, 8'h00, 8'hA5, 3);
        check_log("s1", base);

        // Posted write, forwarded read, forward on the drain-ack cycle, then memory.
        restart();
        base = req_log.size();
        exp_req(1'b1, 16'h0200, 8'h3C);
        exp_req(1'b0, 16'h0200, 8'h00);
        run(0, "s2_write",   1'b1, 16'h0200, 8'h3C, 8'h00, 1);
        run(0, "s2_hit",     1'b0, 16'h0200, 8'h00, 8'h3C, 1);
        run(0, "s2_hit_ack", 1'b0, 16'h0200, 8'h00, 8'h3C, 1);
        run(0, "s2_mem",     1'b0, 16'h0200, 8'h00, 8'h3C, 3);
        check_log("s2", base);

        // Table-driven mixed stream.
        restart();
        ack_delay = 1;
        base = req_log.size();
        exp_req(1'b0, 16'h1235, 8'h00);
        exp_req(1'b1, 16'h0010, 8'hAB);
        exp_req(1'b0, 16'h0020, 8'h00);
        exp_req(1'b1, 16'h0030, 8'h11);
        exp_req(1'b1, 16'h0040, 8'h22);
        exp_req(1'b0, 16'h0030, 8'h00);
        exp_req(1'b0, 16'h0040, 8'h00);
        exp_req(1'b1, 16'h0050, 8'h33);
        exp_req(1'b0, 16'h0051, 8'h00);
        for (int i = 0; i < 10; i++)
            run(0, $sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_data, vt[i].exp_lat);
        check_log("vec", base);

        // Back-to-back writes with a slow drain keep memory order.
        restart();
        ack_delay = 4;
        base = req_log.size();
        exp_req(1'b1, 16'h0200, 8'h01);
        exp_req(1'b1, 16'h0300, 8'h02);
        exp_req(1'b0, 16'h0400, 8'h00);
        run(0, "s3_wr0", 1'b1, 16'h0200, 8'h01, 8'h00, 1);
        run(0, "s3_wr1", 1'b1, 16'h0300, 8'h02, 8'h00, 7);
        run(0, "s3_rd",  1'b0, 16'h0400, 8'h00, 8'h5E, 13);
        check_log("s3", base);

        // Watchdog: hung read, then a dropped drain followed by another hung read.
        restart();
        ack_delay = 0;
        hang = 1'b1;
        base = req_log.size();
        eb = err_pulses;
        exp_req(1'b0, 16'h0777, 8'h00);
        run(0, "s4_hung_read", 1'b0, 16'h0777, 8'h00, 8'hFF, 10);
        check("s4_err_pulses", err_pulses - eb, 1);
        exp_req(1'b1, 16'h0900, 8'h44);
        exp_req(1'b0, 16'h0A00, 8'h00);
        run(0, "s4_post",      1'b1, 16'h0900, 8'h44, 8'h00, 1);
        run(0, "s4_drain_to",  1'b0, 16'h0A00, 8'h00, 8'hFF, 19);
        check("s4_err_pulses_total", err_pulses - eb, 3);
        hang = 1'b0;
        exp_req(1'b0, 16'h0900, 8'h00);
        run(0, "s4_dropped", 1'b0, 16'h0900, 8'h00, 8'h53, 3);
        check_log("s4", base);

        // Reset while a drain is outstanding and the buffer is full.
        restart();
        ack_delay = 6;
        run(0, "s6_post", 1'b1, 16'h0500, 8'h99, 8'h00, 1);
        cpu_write   = 1'b0;
        cpu_address = 16'h0600;
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("s6_req_up", mem_req, 1'b1);
        check("s6_stalled", ready, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("s6_req_drop", mem_req, 1'b0);
        check("s6_we_drop", mem_we, 1'b0);
        ack_delay = 0;
        restart();
        base = req_log.size();
        exp_req(1'b0, 16'h1234, 8'h00);
        run(0, "s6_read", 1'b0, 16'h1234, 8'h00, 8'hA5, 3);
        check_log("s6", base);
        check("s6_no_stale_write", store.exists(16'h0500), 0);
        reset_n = 1'b0;

        // Unposted writes: completion waits for the ack or the watchdog.
        repeat (2) @(posedge clk);
        #1;
        np_reset_n = 1'b1;
        np_delay = 2;
        run(1, "s5_np_write", 1'b1, 16'hC000, 8'h77, 8'h00, 5);
        check("s5_np_req_count", np_log.size(), 1);
        if (np_log.size() > 0) check("s5_np_req", np_log[0], {1'b1, 16'hC000, 8'h77});
        np_hang = 1'b1;
        run(1, "s5_np_timeout", 1'b1, 16'hC001, 8'h12, 8'h00, 10);
        check("s5_np_err_pulses", np_err_pulses, 1);
        np_reset_n = 1'b0;

        check("port_discipline", disc_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
